alu_sequencer: RTL

//  Instruction-issuing front end for the 8-bit ALU datapath. Holds a small loadable program

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Instruction-issuing front end for an external 8-bit ALU: loadable program memory,
// 4x8 register file, fetch/decode/issue FSM with write-back of the returned result.
module alu_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_wdata,
  output logic [2:0]    alu_opcode,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic          alu_valid,
  input  logic [7:0]    alu_result,
  input  logic          alu_carry,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic          carry_flag,
  input  logic [1:0]    dbg_sel,
  output logic [7:0]    dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_ALU  = 2'b00,
    K_LDI  = 2'b01,
    K_HALT = 2'b10,
    K_NOP  = 2'b11
  } kind_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [CW-1:0] cnt;
  logic [7:0]    rf [4];
  logic [15:0]   mem [DEPTH];

  // Instruction fields
  kind_t      kind;
  logic [1:0] rd, ra, rb;
  logic [7:0] imm8;

  assign kind = kind_t'(ir[12:11]);
  assign rd   = ir[10:9];
  assign ra   = ir[8:7];
  assign rb   = ir[6:5];
  assign imm8 = ir[7:0];

  // Instruction retires this cycle without a branch to DONE via HALT.
  logic advance;
  logic at_end;

  assign advance = ((state == S_EXEC) && ((kind == K_LDI) || (kind == K_NOP))) ||
                   ((state == S_WAIT) && (cnt == '0));
  assign at_end  = (pc == AW'(DEPTH - 1));

  assign dbg_data = rf[dbg_sel];

  // NOTE: program memory has no reset so it maps onto RAM and survives rst.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && prog_we) mem[prog_addr] <= prog_wdata;
  end

  // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      cnt        <= '0;
      rf         <= '{default: 8'h00};
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc      <= '0;
            overrun <= 1'b0;
            busy    <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= mem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (kind)
            K_ALU: begin
              alu_opcode <= ir[15:13];
              alu_a      <= rf[ra];
              alu_b      <= rf[rb];
              cnt        <= CW'(ALU_LAT - 1);
              alu_valid  <= 1'b1;
              state      <= S_WAIT;
            end
            K_LDI:   rf[rd] <= imm8;
            K_HALT: begin
              done  <= 1'b1;
              state <= S_DONE;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          // Only the value present on the final valid cycle is written back.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rf[rd]     <= alu_result;
            carry_flag <= alu_carry;
            alu_valid  <= 1'b0;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (advance) begin
        if (at_end) begin
          overrun <= 1'b1;
          done    <= 1'b1;
          state   <= S_DONE;
        end else begin
          pc    <= pc + AW'(1);
          state <= S_FETCH;
        end
      end
    end
  end

endmodule
